// File: rtl/note_sequencer.sv
// note_sequencer: records up to 16 {note, octave} entries and plays them back.
// Each stored note sounds for NOTE_TICKS cycles and is followed by GAP_TICKS
// silent cycles. All state, counters and outputs are registered.
// Optional feature macro: LOOP_PLAYBACK_EN. When it is defined, playback wraps
// to entry 0 after the last gap and keeps running until play_stop or reset.
module note_sequencer #(
  parameter int unsigned NOTE_TICKS = 32'd12500000,
  parameter int unsigned GAP_TICKS  = 32'd2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rec_valid,
  input  logic [3:0] rec_note,
  input  logic [1:0] rec_octave,
  input  logic       play_start,
  input  logic       play_stop,
  input  logic       clear,
  output logic [3:0] out_note,
  output logic [1:0] out_octave,
  output logic       out_valid,
  output logic [3:0] note_index,
  output logic [4:0] count,
  output logic       busy,
  output logic       done,
  output logic       full,
  output logic       empty
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Terminal timer values; the gap value is only used when GAP_TICKS > 0.
  localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 32'd1);
  localparam logic [31:0] GAP_LAST  = (GAP_TICKS == 32'd0) ? 32'd0 : 32'(GAP_TICKS - 32'd1);
  localparam logic        GAP_SKIP  = (GAP_TICKS == 32'd0);

  state_t      r_state;
  logic [31:0] r_timer;
  logic [3:0]  r_note_index;
  logic [4:0]  r_count;
  logic [3:0]  r_out_note;
  logic [1:0]  r_out_octave;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_full;
  logic        r_empty;
  logic [5:0]  r_mem [16];

  logic        w_rec_ok;
  logic        w_start_ok;
  logic        w_adv;
  logic        w_last;
  logic [3:0]  w_next_idx;
  logic [5:0]  w_next_entry;
  logic [5:0]  w_first_entry;

  // Decode record/start acceptance and the end-of-note-slot condition.
  always_comb begin
    w_rec_ok      = 1'b0;
    w_start_ok    = 1'b0;
    w_adv         = 1'b0;
    w_last        = 1'b0;
    w_next_idx    = r_note_index + 4'd1;
    w_next_entry  = r_mem[w_next_idx];
    w_first_entry = r_mem[4'd0];
    if (r_state == ST_IDLE) begin
      w_rec_ok   = rec_valid && !clear && !r_full && !reset;
      w_start_ok = play_start && !play_stop && !clear && (r_count != 5'd0);
    end else begin
      w_rec_ok   = 1'b0;
      w_start_ok = 1'b0;
    end
    if (r_state == ST_PLAY) begin
      w_adv = GAP_SKIP && (r_timer == NOTE_LAST);
    end else if (r_state == ST_GAP) begin
      w_adv = (r_timer == GAP_LAST);
    end else begin
      w_adv = 1'b0;
    end
    w_last = (({1'b0, r_note_index} + 5'd1) >= r_count);
  end

  // Note buffer write port; contents survive reset and clear by design.
  always_ff @(posedge clk) begin
    if (w_rec_ok) begin
      r_mem[r_count[3:0]] <= {rec_note, rec_octave};
    end
  end

  // Main FSM: state, timer, count, flags and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= 32'd0;
      r_note_index <= 4'd0;
      r_count      <= 5'd0;
      r_out_note   <= 4'd0;
      r_out_octave <= 2'd0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
    end else if ((r_state != ST_IDLE) && play_stop) begin
      // Abort: return silently to IDLE, buffer and count untouched.
      r_state      <= ST_IDLE;
      r_timer      <= 32'd0;
      r_note_index <= 4'd0;
      r_out_note   <= 4'd0;
      r_out_octave <= 2'd0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_adv) begin
      r_timer <= 32'd0;
      if (!w_last) begin
        r_state      <= ST_PLAY;
        r_note_index <= w_next_idx;
        r_out_note   <= w_next_entry[5:2];
        r_out_octave <= w_next_entry[1:0];
        r_out_valid  <= 1'b1;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
      end else begin
`ifdef LOOP_PLAYBACK_EN
        r_state      <= ST_PLAY;
        r_note_index <= 4'd0;
        r_out_note   <= w_first_entry[5:2];
        r_out_octave <= w_first_entry[1:0];
        r_out_valid  <= 1'b1;
        r_busy       <= 1'b1;
        r_done       <= 1'b1;
`else
        r_state      <= ST_IDLE;
        r_note_index <= 4'd0;
        r_out_note   <= 4'd0;
        r_out_octave <= 2'd0;
        r_out_valid  <= 1'b0;
        r_busy       <= 1'b0;
        r_done       <= 1'b1;
`endif
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_count <= 5'd0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
          end else if (w_rec_ok) begin
            r_count <= r_count + 5'd1;
            r_full  <= (r_count == 5'd15);
            r_empty <= 1'b0;
          end else begin
            r_count <= r_count;
          end
          if (w_start_ok) begin
            r_state      <= ST_PLAY;
            r_timer      <= 32'd0;
            r_note_index <= 4'd0;
            r_out_note   <= w_first_entry[5:2];
            r_out_octave <= w_first_entry[1:0];
            r_out_valid  <= 1'b1;
            r_busy       <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (r_timer == NOTE_LAST) begin
            r_state      <= ST_GAP;
            r_timer      <= 32'd0;
            r_out_note   <= 4'd0;
            r_out_octave <= 2'd0;
            r_out_valid  <= 1'b0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        ST_GAP: begin
          r_timer <= r_timer + 32'd1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_timer      <= 32'd0;
          r_note_index <= 4'd0;
          r_out_note   <= 4'd0;
          r_out_octave <= 2'd0;
          r_out_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign out_note   = r_out_note;
  assign out_octave = r_out_octave;
  assign out_valid  = r_out_valid;
  assign note_index = r_note_index;
  assign count      = r_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign full       = r_full;
  assign empty      = r_empty;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer with NOTE_TICKS=4, GAP_TICKS=2.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rec_valid = 1'b0;
  logic [3:0] rec_note = 4'd0;
  logic [1:0] rec_octave = 2'd0;
  logic       play_start = 1'b0;
  logic       play_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] out_note;
  logic [1:0] out_octave;
  logic       out_valid;
  logic [3:0] note_index;
  logic [4:0] count;
  logic       busy;
  logic       done;
  logic       full;
  logic       empty;

  int n_tests = 0;
  int n_fail  = 0;

  note_sequencer #(.NOTE_TICKS(32'd4), .GAP_TICKS(32'd2)) dut (
    .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_note(rec_note),
    .rec_octave(rec_octave), .play_start(play_start), .play_stop(play_stop),
    .clear(clear), .out_note(out_note), .out_octave(out_octave),
    .out_valid(out_valid), .note_index(note_index), .count(count),
    .busy(busy), .done(done), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input logic [3:0] n, input logic [1:0] o);
    rec_valid = 1'b1; rec_note = n; rec_octave = o;
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".count"}, 32'(count), 32'd0);
    check_eq({tag, ".empty"}, 32'(empty), 32'd1);
    check_eq({tag, ".full"}, 32'(full), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".note"}, 32'(out_note), 32'd0);
    check_eq({tag, ".oct"}, 32'(out_octave), 32'd0);
    check_eq({tag, ".idx"}, 32'(note_index), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
  endtask

  logic [3:0] exp_note [3];
  logic [1:0] exp_oct  [3];

  initial begin
    exp_note[0] = 4'd1;  exp_oct[0] = 2'd0;
    exp_note[1] = 4'd5;  exp_oct[1] = 2'd1;
    exp_note[2] = 4'd12; exp_oct[2] = 2'd3;

    tick(); tick();
    reset = 1'b0;
    tick();
    check_reset_state("rst");

    // Record three notes.
    record(4'd1, 2'd0);
    record(4'd5, 2'd1);
    record(4'd12, 2'd3);
    check_eq("rec3.count", 32'(count), 32'd3);
    check_eq("rec3.empty", 32'(empty), 32'd0);
    check_eq("rec3.full", 32'(full), 32'd0);

    // Full single-pass playback; rec_valid and clear while busy are ignored.
    play_start = 1'b1; tick(); play_start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      int n; int ph; logic v;
      n  = k / 6;
      ph = k % 6;
      v  = (ph < 4);
      check_eq($sformatf("play%0d.valid", k), 32'(out_valid), 32'(v));
      check_eq($sformatf("play%0d.note", k), 32'(out_note), v ? 32'(exp_note[n]) : 32'd0);
      check_eq($sformatf("play%0d.oct", k), 32'(out_octave), v ? 32'(exp_oct[n]) : 32'd0);
      check_eq($sformatf("play%0d.idx", k), 32'(note_index), 32'(n));
      check_eq($sformatf("play%0d.busy", k), 32'(busy), 32'd1);
      check_eq($sformatf("play%0d.done", k), 32'(done), 32'd0);
      rec_valid = (k == 2);
      rec_note  = 4'd9;
      clear     = (k == 3);
      tick();
      rec_valid = 1'b0;
      clear     = 1'b0;
    end
    check_eq("end.done", 32'(done), 32'd1);
    check_eq("end.busy", 32'(busy), 32'd0);
    check_eq("end.valid", 32'(out_valid), 32'd0);
    check_eq("end.count", 32'(count), 32'd3);
    tick();
    check_eq("end+1.done", 32'(done), 32'd0);
    check_eq("end+1.busy", 32'(busy), 32'd0);

    // Abort on the 2nd cycle of note index 1.
    play_start = 1'b1; tick(); play_start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_eq("stop.pre_idx", 32'(note_index), 32'd1);
    check_eq("stop.pre_valid", 32'(out_valid), 32'd1);
    play_stop = 1'b1; play_start = 1'b1; tick(); play_stop = 1'b0; play_start = 1'b0;
    check_eq("stop.valid", 32'(out_valid), 32'd0);
    check_eq("stop.busy", 32'(busy), 32'd0);
    check_eq("stop.idx", 32'(note_index), 32'd0);
    check_eq("stop.count", 32'(count), 32'd3);
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
        seen_done = seen_done | done | busy;
        tick();
      end
      check_eq("stop.quiet", 32'(seen_done), 32'd0);
    end

    // play_stop beats play_start in IDLE.
    play_stop = 1'b1; play_start = 1'b1; tick(); play_stop = 1'b0; play_start = 1'b0;
    check_eq("prio.busy", 32'(busy), 32'd0);

    // Reset in the middle of PLAY.
    play_start = 1'b1; tick(); play_start = 1'b0;
    tick();
    check_eq("midrst.pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1; play_start = 1'b1; tick(); reset = 1'b0; play_start = 1'b0;
    check_reset_state("midrst");

    // play_start with an empty buffer is ignored.
    play_start = 1'b1; tick(); play_start = 1'b0;
    check_eq("empty_play.busy", 32'(busy), 32'd0);
    check_eq("empty_play.valid", 32'(out_valid), 32'd0);

    // clear wins over simultaneous rec_valid.
    record(4'd3, 2'd2);
    check_eq("clr.pre_count", 32'(count), 32'd1);
    clear = 1'b1; rec_valid = 1'b1; tick(); clear = 1'b0; rec_valid = 1'b0;
    check_eq("clr.count", 32'(count), 32'd0);
    check_eq("clr.empty", 32'(empty), 32'd1);

    // Fill all 16 entries, then a 17th record must be ignored.
    for (int i = 0; i < 16; i++) record(4'(i), 2'(i % 4));
    check_eq("full.count", 32'(count), 32'd16);
    check_eq("full.full", 32'(full), 32'd1);
    check_eq("full.empty", 32'(empty), 32'd0);
    record(4'd9, 2'd2);
    check_eq("full17.count", 32'(count), 32'd16);
    check_eq("full17.full", 32'(full), 32'd1);

    // Play all 16 entries back; entry 15 must still be (15,3).
    play_start = 1'b1; tick(); play_start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      check_eq($sformatf("p16_%0d.idx", n), 32'(note_index), 32'(n));
      check_eq($sformatf("p16_%0d.note", n), 32'(out_note), 32'(n));
      check_eq($sformatf("p16_%0d.oct", n), 32'(out_octave), 32'(n % 4));
      for (int k = 0; k < 6; k++) tick();
    end
    check_eq("p16.done", 32'(done), 32'd1);
    check_eq("p16.busy", 32'(busy), 32'd0);

    // clear in IDLE empties the buffer.
    clear = 1'b1; tick(); clear = 1'b0;
    check_eq("clr16.count", 32'(count), 32'd0);
    check_eq("clr16.full", 32'(full), 32'd0);
    check_eq("clr16.empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
